mod_dm: RTL

//  MEM-stage data memory feeding the load extender (mod_dmtender) in WB.

---
 rtl/mod_dm.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mod_dm.sv
// mod_dm: MEM-stage data memory with byte-lane stores and a registered
// MEM/WB boundary (read word, addr[1:0], extender type, align flag).
//
// Parameters: DEPTH (words, power of two), AW = log2(DEPTH).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   en                stage enable (0 = stall: hold outputs, no write)
//   addr[31:0]        byte address; word index = addr[AW+1:2]
//   wd[31:0]          unshifted store data
//   mem_write         store this cycle
//   store_type[1:0]   0=sw 1=sh 2=sb 3=reserved (no write)
//   dmtender_type[2:0] extender code, passed through
//   dm_data[31:0]     registered aligned read word
//   addr_lo[1:0]      registered addr[1:0]
//   dmtender_out[2:0] registered dmtender_type
//   align_exc         registered misaligned-store flag
// Optional feature macro: DM_ALIGN_EXC_EN (alignment check on stores).
module mod_dm #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        mem_write,
    input  logic [1:0]  store_type,
    input  logic [2:0]  dmtender_type,
    output logic [31:0] dm_data,
    output logic [1:0]  addr_lo,
    output logic [2:0]  dmtender_out,
    output logic        align_exc
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] dm_data_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  dmtender_q;

    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [3:0]    be_eff;
    logic [31:0]   lane;
    logic [31:0]   merged_d;
    logic          misalign;

    // High address bits are intentionally ignored (addresses wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign idx = addr[AW+1:2];

    always_comb begin
        be   = 4'b0000;
        lane = wd;
        unique case (store_type)
            2'd0: begin
                be   = 4'b1111;
                lane = wd;
            end
            2'd1: begin
                be   = addr[1] ? 4'b1100 : 4'b0011;
                lane = {2{wd[15:0]}};
            end
            2'd2: begin
                be   = 4'b0001 << addr[1:0];
                lane = {4{wd[7:0]}};
            end
            default: begin
                be   = 4'b0000;
                lane = wd;
            end
        endcase
    end

`ifdef DM_ALIGN_EXC_EN
    always_comb begin
        misalign = 1'b0;
        if (mem_write) begin
            if (store_type == 2'd0 && addr[1:0] != 2'b00)
                misalign = 1'b1;
            if (store_type == 2'd1 && addr[0])
                misalign = 1'b1;
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Misaligned stores (when checked) are squashed to no lanes.
    assign be_eff = (mem_write && !misalign) ? be : 4'b0000;

    // Write-first: the read word already carries this cycle's store bytes.
    always_comb begin
        merged_d = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (be_eff[b])
                merged_d[8*b +: 8] = lane[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 32'h0;
            dm_data_q  <= 32'h0;
            addr_lo_q  <= 2'b00;
            dmtender_q <= 3'b000;
        end else if (en) begin
            if (be_eff != 4'b0000)
                mem_q[idx] <= merged_d;
            dm_data_q  <= merged_d;
            addr_lo_q  <= addr[1:0];
            dmtender_q <= dmtender_type;
        end
    end

`ifdef DM_ALIGN_EXC_EN
    logic align_exc_q;
    always_ff @(posedge clk) begin
        if (reset)
            align_exc_q <= 1'b0;
        else if (en)
            align_exc_q <= misalign;
    end
    assign align_exc = align_exc_q;
`else
    assign align_exc = 1'b0;
`endif

    assign dm_data      = dm_data_q;
    assign addr_lo      = addr_lo_q;
    assign dmtender_out = dmtender_q;

endmodule
